// File: rtl/output_compactor.sv
// output_compactor: folds observed output bits into a MISR. Every WINDOW accepted
// samples the signature is snapshotted into a shadow register and shifted out
// MSB first on sig_serial, framed by sig_frame.
// Optional feature: define COMPACTOR_PARITY_EN to append one parity bit (XOR of
// all signature bits) to every frame.
module output_compactor #(
    parameter int unsigned       WIDTH    = 32,
    parameter int unsigned       IN_WIDTH = 2,
    parameter logic [WIDTH-1:0]  POLY     = WIDTH'(32'h04C11DB7),
    parameter logic [WIDTH-1:0]  SEED     = WIDTH'(32'hFFFFFFFF),
    parameter int unsigned       WINDOW   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] din,
    input  logic                din_valid,
    output logic                sig_serial,
    output logic                sig_frame,
    output logic                overrun
);

`ifdef COMPACTOR_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [WIDTH-1:0] r_misr;
    logic [WIDTH-1:0] r_shadow;
    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;

    logic [WIDTH-1:0] w_din_ext;
    logic [WIDTH-1:0] w_misr_next;
    logic             w_snapshot;
    logic             w_last;
    logic [IDX_W-1:0] w_idx;
    logic             w_bit;

    // Next MISR value: shift, conditional polynomial feedback, fold in the sample
    always_comb begin
        w_din_ext                 = '0;
        w_din_ext[IN_WIDTH-1:0]   = din;
        w_misr_next = {r_misr[WIDTH-2:0], 1'b0}
                    ^ (r_misr[WIDTH-1] ? POLY : '0)
                    ^ w_din_ext;
    end

    assign w_snapshot = din_valid && (r_win == WIN_W'(WINDOW - 1));
    assign w_last     = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_idx      = IDX_W'(WIDTH - 1) - r_cnt[IDX_W-1:0];

    // Bit to present on the serial pin for the current frame position
    always_comb begin
`ifdef COMPACTOR_PARITY_EN
        if (r_cnt == CNT_W'(WIDTH)) begin
            w_bit = ^r_shadow;
        end else begin
            w_bit = r_shadow[w_idx];
        end
`else
        w_bit = r_shadow[w_idx];
`endif
    end

    // Signature accumulation and window counting; reseed on every snapshot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misr <= SEED;
            r_win  <= '0;
        end else if (din_valid) begin
            if (w_snapshot) begin
                r_misr <= SEED;
                r_win  <= '0;
            end else begin
                r_misr <= w_misr_next;
                r_win  <= r_win + WIN_W'(1);
            end
        end
    end

    // Shift-out FSM with registered outputs; snapshots while SHIFT are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shadow   <= '0;
            sig_serial <= 1'b0;
            sig_frame  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // The SHIFT->IDLE edge still counts as busy, so only IDLE accepts
            if (w_snapshot) begin
                if (r_state == IDLE) begin
                    r_shadow <= w_misr_next;
                end else begin
                    overrun <= 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    sig_frame  <= 1'b0;
                    sig_serial <= 1'b0;
                    if (w_snapshot) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sig_frame  <= 1'b1;
                    sig_serial <= w_bit;
                    if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    sig_frame  <= 1'b0;
                    sig_serial <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_compactor.sv
// Testbench for output_compactor: three instances (WINDOW 4, 1 and 10) share the
// stimulus and are compared every cycle against a queue-based reference model.
module tb_output_compactor;

`ifdef COMPACTOR_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] din;
    logic       din_valid;
    logic [2:0] ser;
    logic [2:0] frm;
    logic [2:0] ovr;

    always #5 clk = ~clk;

    output_compactor #(.WIDTH(8), .IN_WIDTH(2), .POLY(8'h1D), .SEED(8'h01), .WINDOW(4)) u_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sig_serial(ser[0]), .sig_frame(frm[0]), .overrun(ovr[0]));
    output_compactor #(.WIDTH(8), .IN_WIDTH(2), .POLY(8'h1D), .SEED(8'h80), .WINDOW(1)) u_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sig_serial(ser[1]), .sig_frame(frm[1]), .overrun(ovr[1]));
    output_compactor #(.WIDTH(8), .IN_WIDTH(2), .POLY(8'h1D), .SEED(8'h01), .WINDOW(10)) u_c (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sig_serial(ser[2]), .sig_frame(frm[2]), .overrun(ovr[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: signature arithmetic plus a queue of bits still to be sent
    int m_win[3];
    int m_seed[3];
    int m_misr[3];
    int m_cnt[3];
    bit m_ovr[3];
    bit m_q[3][$];
    bit e_frm[3];
    bit e_ser[3];

    logic [31:0] cap_a;
    logic [31:0] cap_b;
    int          n_a;
    int          n_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_misr[i] = m_seed[i];
            m_cnt[i]  = 0;
            m_ovr[i]  = 1'b0;
            m_q[i].delete();
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit busy;
            int nxt;
            busy     = (m_q[i].size() != 0);
            e_frm[i] = busy;
            e_ser[i] = busy ? m_q[i].pop_front() : 1'b0;
            if (din_valid) begin
                nxt = ((m_misr[i] * 2) % 256) ^ ((m_misr[i] >= 128) ? 29 : 0) ^ int'(din);
                if (m_cnt[i] == m_win[i] - 1) begin
                    m_cnt[i]  = 0;
                    m_misr[i] = m_seed[i];
                    if (busy) begin
                        m_ovr[i] = 1'b1;
                    end else begin
                        for (int b = 7; b >= 0; b--) m_q[i].push_back(bit'((nxt >> b) & 1));
                        if (FL == 9) m_q[i].push_back(bit'($countones(nxt) & 1));
                    end
                end else begin
                    m_misr[i] = nxt;
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("frame%0d", i), 32'(frm[i]), 32'(e_frm[i]));
            check($sformatf("serial%0d", i), 32'(ser[i]), 32'(e_ser[i]));
            check($sformatf("overrun%0d", i), 32'(ovr[i]), 32'(m_ovr[i]));
        end
        check("misr_a", 32'(u_a.r_misr), 32'(m_misr[0]));
        if (frm[0]) begin
            cap_a = {cap_a[30:0], ser[0]};
            n_a++;
        end
        if (frm[1]) begin
            cap_b = {cap_b[30:0], ser[1]};
            n_b++;
        end
    endtask

    task automatic run(input int n, input bit v, input logic [1:0] d);
        for (int k = 0; k < n; k++) begin
            din_valid = v;
            din       = d;
            tick();
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        din_valid = 1'b0;
        din       = 2'b00;
        #1 reset = 1'b1;
        #1;
        check("rst_frame", 32'(frm), 32'd0);
        check("rst_serial", 32'(ser), 32'd0);
        check("rst_overrun", 32'(ovr), 32'd0);
        check("rst_misr_a", 32'(u_a.r_misr), 32'h01);
        check("rst_misr_b", 32'(u_b.r_misr), 32'h80);
        model_reset();
        cap_a = 0;
        cap_b = 0;
        n_a   = 0;
        n_b   = 0;
        #1 reset = 1'b0;
    endtask

    initial begin
        m_win  = '{4, 1, 10};
        m_seed = '{1, 128, 1};
        reset     = 1'b0;
        din       = 2'b00;
        din_valid = 1'b0;
        do_reset();

        // Feedback wrap on the WINDOW=1, SEED=80 instance
        run(1, 1'b1, 2'b11);
        run(14, 1'b0, 2'b00);
        check("feedback_sig", cap_b, (FL == 9) ? 32'h03C : 32'h1E);
        check("feedback_len", n_b, FL);

        // Basic window
        do_reset();
        run(4, 1'b1, 2'b00);
        run(14, 1'b0, 2'b00);
        check("basic_sig", cap_a, (FL == 9) ? 32'h021 : 32'h10);
        check("basic_len", n_a, FL);
        check("basic_ovr", 32'(ovr[0]), 32'd0);

        // Valid gaps
        do_reset();
        for (int k = 0; k < 8; k++) run(1, (k % 2) == 0, 2'b00);
        run(14, 1'b0, 2'b00);
        check("gaps_sig", cap_a, (FL == 9) ? 32'h021 : 32'h10);

        // Overrun: later snapshots fall inside the first frame
        do_reset();
        run(12, 1'b1, 2'b00);
        run(14, 1'b0, 2'b00);
        check("ovr_sig", cap_a, (FL == 9) ? 32'h021 : 32'h10);
        check("ovr_len", n_a, FL);
        check("ovr_flag", 32'(ovr[0]), 32'd1);

        // Reset on the 4th frame bit, then a full new window is needed
        do_reset();
        run(8, 1'b1, 2'b00);
        check("mid_frame_active", 32'(frm[0]), 32'd1);
        do_reset();
        run(3, 1'b1, 2'b00);
        run(12, 1'b0, 2'b00);
        check("mid_no_frame", n_a, 0);
        run(1, 1'b1, 2'b00);
        run(14, 1'b0, 2'b00);
        check("mid_sig", cap_a, (FL == 9) ? 32'h021 : 32'h10);

        // Randomized traffic; WINDOW=10 instance must never overrun
        do_reset();
        for (int k = 0; k < 600; k++) begin
            run(1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
        end
        run(15, 1'b0, 2'b00);
        check("rand_no_ovr_c", 32'(ovr[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
